// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared types and the priority pick for the memory-port arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_BUSY = 2'd1,
    ARB_D_BUSY = 2'd2
  } memArbState;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } memGrant;

  // Data wins a tie unless fetch has been starved for the full limit.
  function automatic memGrant pick_grant(input logic i_req, input logic d_req,
                                         input logic starved);
    if (d_req && !(i_req && starved)) return GRANT_D;
    return GRANT_I;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_timeout.sv
// ============================================================================
// bus_timeout_counter : counts BUSY cycles and flags the one that hits TIMEOUT
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int              CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // count_q holds the number of BUSY cycles already elapsed, so LAST marks the final one.
  assign expire_o = enable_i & (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one memory port between instruction fetch and load/store
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int BIT_COUNT    = 32,
  parameter int WORD_SIZE    = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   IReq_i,
  input  logic [BIT_COUNT-1:0]   IAdr_i,
  output logic                   IReady_o,
  output logic [WORD_SIZE-1:0]   IRData_o,
  input  logic                   DReq_i,
  input  logic                   DWrite_i,
  input  logic [WORD_SIZE/8-1:0] DByteEn_i,
  input  logic [BIT_COUNT-1:0]   DAdr_i,
  input  logic [WORD_SIZE-1:0]   DWData_i,
  output logic                   DReady_o,
  output logic [WORD_SIZE-1:0]   DRData_o,
  output logic                   BusErr_o,
  output logic                   MemEn_o,
  output logic                   MemWrite_o,
  output logic [WORD_SIZE/8-1:0] ByteEn_o,
  output logic [BIT_COUNT-1:0]   MemAdr_o,
  output logic [WORD_SIZE-1:0]   MemWriteData_o,
  input  logic                   MemAck_i,
  input  logic [WORD_SIZE-1:0]   MemReadData_i
);

  localparam int                BE_W       = WORD_SIZE / 8;
  localparam int                SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);

  memArbState           state_q, state_d;
  logic [SC_W-1:0]      starve_q, starve_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_write_q, mem_write_d;
  logic [BE_W-1:0]      byte_en_q, byte_en_d;
  logic [BIT_COUNT-1:0] mem_adr_q, mem_adr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 i_ready_q, i_ready_d;
  logic                 d_ready_q, d_ready_d;
  logic                 bus_err_q, bus_err_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;

  logic    i_req_w, d_req_w, busy_w, expire_w, done_w, grant_en_w;
  memGrant grant_w;

  // A side that is finishing this cycle is still holding its old request; ignore it.
  assign i_req_w    = IReq_i & ~i_ready_q;
  assign d_req_w    = DReq_i & ~d_ready_q;
  assign grant_w    = pick_grant(i_req_w, d_req_w, starve_q == STARVE_MAX);
  assign busy_w     = (state_q != ARB_IDLE);
  assign grant_en_w = (state_q == ARB_IDLE) & (i_req_w | d_req_w);
  assign done_w     = busy_w & (MemAck_i | expire_w);

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (grant_en_w),
    .enable_i (busy_w),
    .expire_o (expire_w)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      byte_en_q   <= '0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_write_q <= mem_write_d;
      byte_en_q   <= byte_en_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_en_w) state_d = (grant_w == GRANT_D) ? ARB_D_BUSY : ARB_I_BUSY;
      end
      ARB_I_BUSY, ARB_D_BUSY: begin
        if (done_w) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_en_d    = mem_en_q;
    mem_write_d = mem_write_q;
    byte_en_d   = byte_en_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    starve_d    = starve_q;
    if (grant_en_w) begin
      mem_en_d = 1'b1;
      if (grant_w == GRANT_D) begin
        mem_write_d = DWrite_i;
        byte_en_d   = DByteEn_i;
        mem_adr_d   = DAdr_i;
        mem_wdata_d = DWData_i;
        if (i_req_w && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
      end else begin
        mem_write_d = 1'b0;
        byte_en_d   = '1;
        mem_adr_d   = IAdr_i;
        mem_wdata_d = '0;
        starve_d    = '0;
      end
    end else if (done_w) begin
      // An acknowledge on the expiry cycle still counts as a normal completion.
      mem_en_d    = 1'b0;
      mem_write_d = 1'b0;
      bus_err_d   = ~MemAck_i;
      if (state_q == ARB_D_BUSY) begin
        d_ready_d = 1'b1;
        d_rdata_d = MemAck_i ? MemReadData_i : '0;
      end else begin
        i_ready_d = 1'b1;
        i_rdata_d = MemAck_i ? MemReadData_i : '0;
      end
    end
  end

  assign IReady_o       = i_ready_q;
  assign IRData_o       = i_rdata_q;
  assign DReady_o       = d_ready_q;
  assign DRData_o       = d_rdata_q;
  assign BusErr_o       = bus_err_q;
  assign MemEn_o        = mem_en_q;
  assign MemWrite_o     = mem_write_q;
  assign ByteEn_o       = byte_en_q;
  assign MemAdr_o       = mem_adr_q;
  assign MemWriteData_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : randomized scoreboard bench for the memory-port arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int BC = 32;
  localparam int WS = 32;
  localparam int BE = WS / 8;
  localparam int SL = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          IReq, IReady, DReq, DWrite, DReady, BusErr;
  logic [BC-1:0] IAdr, DAdr, MemAdr;
  logic [WS-1:0] IRData, DWData, DRData, MemWriteData, MemReadData;
  logic [BE-1:0] DByteEn, ByteEn;
  logic          MemEn, MemWrite, MemAck;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .BIT_COUNT (BC), .WORD_SIZE (WS), .STARVE_LIMIT (SL), .TIMEOUT (TO)
  ) dut (
    .clk_i (clk), .reset_i (reset),
    .IReq_i (IReq), .IAdr_i (IAdr), .IReady_o (IReady), .IRData_o (IRData),
    .DReq_i (DReq), .DWrite_i (DWrite), .DByteEn_i (DByteEn), .DAdr_i (DAdr),
    .DWData_i (DWData), .DReady_o (DReady), .DRData_o (DRData), .BusErr_o (BusErr),
    .MemEn_o (MemEn), .MemWrite_o (MemWrite), .ByteEn_o (ByteEn), .MemAdr_o (MemAdr),
    .MemWriteData_o (MemWriteData), .MemAck_i (MemAck), .MemReadData_i (MemReadData)
  );

  typedef struct {
    int            cyc;
    logic          wr;
    logic [BE-1:0] be;
    logic [BC-1:0] adr;
    logic [WS-1:0] wd;
  } mem_t;

  typedef struct {
    int            cyc;
    logic [WS-1:0] data;
    logic          err;
  } rsp_t;

  mem_t exp_mem_q[$];
  rsp_t exp_i_q[$];
  rsp_t exp_d_q[$];
  bit   exp_en[int];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  mem_t cur;
  rsp_t mr;
  logic prev_en = 1'b0;
  bit   ie, de;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("MemEn", MemEn, exp_en.exists(cyc));
      if (exp_en.exists(cyc)) exp_en.delete(cyc);
      if (MemEn && !prev_en) begin
        check("grant_cycle", cyc, (exp_mem_q.size() > 0) ? exp_mem_q[0].cyc : -1);
        if (exp_mem_q.size() > 0 && exp_mem_q[0].cyc == cyc) cur = exp_mem_q.pop_front();
      end
      if (MemEn) begin
        check("MemWrite", MemWrite, cur.wr);
        check("ByteEn", ByteEn, cur.be);
        check("MemAdr", MemAdr, cur.adr);
        check("MemWriteData", MemWriteData, cur.wd);
      end
      prev_en = MemEn;
      ie = (exp_i_q.size() > 0) && (exp_i_q[0].cyc == cyc);
      de = (exp_d_q.size() > 0) && (exp_d_q[0].cyc == cyc);
      check("IReady", IReady, ie);
      check("DReady", DReady, de);
      if (ie) begin
        mr = exp_i_q.pop_front();
        check("IRData", IRData, mr.data);
        check("BusErr_I", BusErr, mr.err);
      end
      if (de) begin
        mr = exp_d_q.pop_front();
        check("DRData", DRData, mr.data);
        check("BusErr_D", BusErr, mr.err);
      end
      if (!ie && !de) check("BusErr_idle", BusErr, 1'b0);
    end
  end

  // ---------------- agents and reference model ----------------
  bit            rst_req = 1'b1;
  bit            i_pend = 0, d_pend = 0;
  logic [BC-1:0] i_adr = '0, d_adr = '0;
  logic          d_write = 1'b0;
  logic [BE-1:0] d_be = '0;
  logic [WS-1:0] d_wdata = '0;
  bit            auto_i = 0, auto_d = 0, rep_i = 0, rep_d = 0;
  bit            stray_en = 0, force_ack = 0, long_en = 0, force_rd_en = 0;
  int            force_lat = -1;
  logic [WS-1:0] force_rd = '0, ack_data = '0;
  int            busy_until = 0, ack_cyc = -1, i_ready_cyc = -1, d_ready_cyc = -1;
  int            starve = 0;

  task automatic new_i();
    i_pend = 1;
    i_adr  = $urandom;
  endtask

  task automatic new_d();
    d_pend  = 1;
    d_write = 1'($urandom_range(0, 1));
    d_be    = BE'($urandom);
    d_adr   = $urandom;
    d_wdata = $urandom;
  endtask

  task automatic flush(input int c);
    while (exp_mem_q.size() > 0 && exp_mem_q[$].cyc > c) void'(exp_mem_q.pop_back());
    while (exp_i_q.size() > 0 && exp_i_q[$].cyc > c) void'(exp_i_q.pop_back());
    while (exp_d_q.size() > 0 && exp_d_q[$].cyc > c) void'(exp_d_q.pop_back());
    for (int k = c + 1; k <= c + TO + 3; k++) if (exp_en.exists(k)) exp_en.delete(k);
    ack_cyc    = -1;
    busy_until = c + 1;
    starve     = 0;
    if (i_ready_cyc > c) i_ready_cyc = -1;
    if (d_ready_cyc > c) d_ready_cyc = -1;
  endtask

  // One grant decided from the request rules; timing derived from the chosen memory latency.
  task automatic arbitrate(input int c);
    bit   iu, du, gd, tmo;
    int   lat, rdy, r;
    logic [WS-1:0] rd;
    mem_t m;
    rsp_t p;
    iu = i_pend && (c != i_ready_cyc);
    du = d_pend && (c != d_ready_cyc);
    if (!(iu || du)) return;
    gd = du && !(iu && starve == SL);
    if (gd) begin
      if (iu && starve < SL) starve++;
    end else begin
      starve = 0;
    end
    tmo = 0;
    lat = 0;
    if (force_lat != -1) begin
      if (force_lat == -2) tmo = 1;
      else lat = force_lat;
      force_lat = -1;
    end else begin
      r = long_en ? int'($urandom_range(0, 15)) : 15;
      if (r == 0) tmo = 1;
      else if (r == 1) lat = TO - 1;
      else lat = int'($urandom_range(0, 3));
    end
    rd = force_rd_en ? force_rd : WS'($urandom);
    force_rd_en = 0;
    if (tmo) begin
      ack_cyc = -1;
      rdy     = c + 1 + TO;
    end else begin
      ack_cyc  = c + 1 + lat;
      ack_data = rd;
      rdy      = c + 2 + lat;
    end
    for (int k = c + 1; k < rdy; k++) exp_en[k] = 1;
    m.cyc = c + 1;
    if (gd) begin
      m.wr = d_write; m.be = d_be; m.adr = d_adr; m.wd = d_wdata;
    end else begin
      m.wr = 1'b0; m.be = '1; m.adr = i_adr; m.wd = '0;
    end
    exp_mem_q.push_back(m);
    p.cyc  = rdy;
    p.data = tmo ? '0 : rd;
    p.err  = tmo;
    if (gd) begin
      exp_d_q.push_back(p);
      d_ready_cyc = rdy;
    end else begin
      exp_i_q.push_back(p);
      i_ready_cyc = rdy;
    end
    busy_until = rdy;
  endtask

  task automatic step();
    int c;
    @(negedge clk);
    c = cyc;
    if (c == i_ready_cyc) begin
      i_pend = 0;
      if (rep_i || (auto_i && $urandom_range(0, 1) == 1)) new_i();
    end else if (!i_pend && auto_i && $urandom_range(0, 3) == 0) begin
      new_i();
    end
    if (c == d_ready_cyc) begin
      d_pend = 0;
      if (rep_d || (auto_d && $urandom_range(0, 1) == 1)) new_d();
    end else if (!d_pend && auto_d && $urandom_range(0, 3) == 0) begin
      new_d();
    end
    reset   = rst_req;
    IReq    = i_pend;
    IAdr    = i_adr;
    DReq    = d_pend;
    DWrite  = d_write;
    DByteEn = d_be;
    DAdr    = d_adr;
    DWData  = d_wdata;
    if (c == ack_cyc) begin
      MemAck      = 1'b1;
      MemReadData = ack_data;
    end else begin
      MemAck      = force_ack || (stray_en && c >= busy_until && $urandom_range(0, 3) == 0);
      MemReadData = $urandom;
    end
    if (rst_req) flush(c);
    else if (c >= busy_until) arbitrate(c);
  endtask

  initial begin
    reset = 1'b1; IReq = 1'b1; IAdr = 32'h100; DReq = 1'b0; DWrite = 1'b0;
    DByteEn = '0; DAdr = '0; DWData = '0; MemAck = 1'b1; MemReadData = '0;

    // reset held with a fetch request and a stray acknowledge present
    i_pend = 1; i_adr = 32'h100; force_ack = 1;
    repeat (3) step();
    force_ack = 0;

    // first fetch, acknowledged one cycle after MemEn
    rst_req = 0; force_lat = 1; force_rd = 32'h00500093; force_rd_en = 1;
    repeat (8) step();

    // simultaneous fetch and store: data first
    i_pend = 1; i_adr = 32'h200;
    d_pend = 1; d_write = 1; d_adr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    repeat (14) step();

    // fetch held while data keeps re-requesting
    rep_i = 1; rep_d = 1; new_i(); new_d();
    repeat (40) step();
    rep_i = 0; rep_d = 0;
    repeat (12) step();

    // data load that never gets acknowledged, then stray acks while idle
    d_pend = 1; d_write = 0; d_adr = 32'h3000; d_be = 4'hF; force_lat = -2;
    stray_en = 1;
    repeat (TO + 12) step();
    stray_en = 0;

    // reset in the middle of a data access
    new_d(); force_lat = 6;
    repeat (3) step();
    d_pend = 0; rst_req = 1;
    step();
    rst_req = 0;
    i_pend = 1; i_adr = 32'h400;
    repeat (12) step();

    // randomized traffic
    auto_i = 1; auto_d = 1; long_en = 1; stray_en = 1;
    repeat (3000) step();
    auto_i = 0; auto_d = 0;
    repeat (3 * TO + 20) step();

    check("leftover_expectations", exp_i_q.size() + exp_d_q.size() + exp_mem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
